seg_decoder: RTL and testbench

- Reverse direction of the 3-bit-to-seven-segment encoder path: recovers the 3-bit digit value from a 7-bit active-low segment pattern.
- Used in board loopback and self-check: samples the segment bus, requires the pattern to be stable for a programmable number of cycles, then reports the value once with a one-cycle strobe.
- Flags patterns outside the 8-entry glyph set as errors and keeps a saturating error count.

---
 rtl/seg_decoder_if.sv | 17 +
 rtl/seg_decoder.sv | 91 +++++++++
 tb/tb_seg_decoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg_decoder_if.sv
// Segment-decoder bus: segment pattern in, decoded digit/error report out.
// Combinational bundle, no latency of its own.
// No backpressure: the report is a strobe the consumer must take when it fires.
interface seg_if #(
    parameter int ERR_CNT_W = 8
);
    logic [6:0]           seg_in;
    logic [2:0]           y_out;
    logic                 err;
    logic                 out_vld;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Pattern source / report consumer
    modport master (output seg_in, input y_out, err, out_vld, err_cnt);
    // Decoder
    modport slave  (input seg_in, output y_out, err, out_vld, err_cnt);
endinterface

// File: rtl/seg_decoder.sv
// Recovers a 3-bit digit from an active-low seven-segment pattern after it is stable.
// Latency: report on edge k+STABLE_CYCLES-1 for a pattern first sampled at edge k.
// No backpressure: out_vld is a one-cycle strobe, y_out/err hold until the next report.
module seg_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    seg_if.slave bus
);
    localparam logic [7:0] SC = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [6:0] seg_q;
    logic [7:0] run, run_nxt;
    logic [6:0] last_pat;
    logic       rep_vld;
    logic       change, reach, accept;
    logic [2:0] dec_y;
    logic       dec_ill;

    // Glyph lookup; anything outside the table decodes to 0 and is flagged
    always_comb begin
        dec_y   = 3'd0;
        dec_ill = 1'b0;
        case (bus.seg_in)
            7'b0000001: dec_y = 3'd0;
            7'b1001111: dec_y = 3'd1;
            7'b0010010: dec_y = 3'd2;
            7'b0000110: dec_y = 3'd3;
            7'b1001100: dec_y = 3'd4;
            7'b0100100: dec_y = 3'd5;
            7'b0100000: dec_y = 3'd6;
            7'b0001111: dec_y = 3'd7;
            default:    dec_ill = 1'b1;
        endcase
    end

    // Run counter, next state and accept decision. IDLE counts as a change so the
    // first sample after reset always starts a fresh run. A run reaching the
    // threshold only matters when it got there on this edge (settling or a change
    // with STABLE_CYCLES=1), so a held LOCKED pattern never re-reports.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        accept    = 1'b0;
        change    = (state == IDLE) || (bus.seg_in != seg_q);
        if (change)
            run_nxt = 8'd1;
        else if (run != SC)
            run_nxt = run + 8'd1;
        reach = (run_nxt == SC) && (change || state == SETTLE);
        if (reach) begin
            state_nxt = LOCKED;
            accept    = !rep_vld || (bus.seg_in != last_pat);
        end else if (change) begin
            state_nxt = SETTLE;
        end
    end

    // State, sampler and report registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            seg_q       <= 7'h7f;
            run         <= 8'd0;
            last_pat    <= 7'h7f;
            rep_vld     <= 1'b0;
            bus.y_out   <= 3'd0;
            bus.err     <= 1'b0;
            bus.out_vld <= 1'b0;
            bus.err_cnt <= '0;
        end else begin
            state       <= state_nxt;
            seg_q       <= bus.seg_in;
            run         <= run_nxt;
            bus.out_vld <= accept;
            if (accept) begin
                last_pat  <= bus.seg_in;
                rep_vld   <= 1'b1;
                bus.y_out <= dec_y;
                bus.err   <= dec_ill;
                if (dec_ill && !(&bus.err_cnt))
                    bus.err_cnt <= bus.err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_decoder.sv
module tb_seg_decoder;
    localparam int S = 4;

    typedef struct {
        int         edge_no;
        logic [2:0] y;
        logic       e;
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   ecnt  = 0;
    exp_t sb[$];

    logic [6:0] glyph [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};

    // reference model state for the STABLE_CYCLES=4 instance
    logic [6:0] m_prev = 7'h00;
    logic [6:0] m_last = 7'h00;
    bit         m_first = 1'b1;
    bit         m_has = 1'b0;
    int         m_run = 0;
    int         m_cnt = 0;

    seg_if #(.ERR_CNT_W(8)) u ();
    seg_if #(.ERR_CNT_W(8)) u1 ();

    seg_decoder #(.STABLE_CYCLES(S), .ERR_CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(u));
    seg_decoder #(.STABLE_CYCLES(1), .ERR_CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(u1));

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic lookup(input logic [6:0] p, output logic [2:0] y, output logic ill);
        y = 3'd0;
        ill = 1'b1;
        for (int i = 0; i < 8; i++)
            if (glyph[i] == p) begin
                y = 3'(i);
                ill = 1'b0;
            end
    endtask

    // Predict what the next edge does for pattern p and queue any expected report
    task automatic model(input logic [6:0] p);
        bit changed;
        int was;
        logic [2:0] y;
        logic ill;
        exp_t x;
        if (!rst) begin
            m_first = 1'b1; m_has = 1'b0; m_run = 0; m_cnt = 0;
            return;
        end
        changed = m_first || (p != m_prev);
        was = m_run;
        if (changed) m_run = 1;
        else if (m_run < S) m_run++;
        if (m_run == S && (changed || was < S) && (!m_has || p != m_last)) begin
            lookup(p, y, ill);
            if (ill && m_cnt < 255) m_cnt++;
            x.edge_no = ecnt + 1; x.y = y; x.e = ill; x.cnt = m_cnt;
            sb.push_back(x);
            m_has = 1'b1;
            m_last = p;
        end
        m_prev = p;
        m_first = 1'b0;
    endtask

    task automatic drive(input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            u.seg_in = p;
            model(p);
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst && u.out_vld) begin
            exp_t x;
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_pulse got 1 expected 0 at edge %0d", ecnt);
            end
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("pulse_edge", ecnt, x.edge_no);
                check("pulse_y", int'(u.y_out), int'(x.y));
                check("pulse_err", int'(u.err), int'(x.e));
                check("pulse_cnt", int'(u.err_cnt), x.cnt);
            end
        end
    end

    initial begin
        u.seg_in = 7'h7f;
        u1.seg_in = 7'h7f;
        drive(7'h7f, 2);
        check("rst_y", int'(u.y_out), 0);
        check("rst_err", int'(u.err), 0);
        check("rst_vld", int'(u.out_vld), 0);
        check("rst_cnt", int'(u.err_cnt), 0);
        check("rst_vld1", int'(u1.out_vld), 0);
        rst = 1'b1;

        // 1: single stable glyph, one report only
        drive(7'b0000110, 10);
        check("t1_y", int'(u.y_out), 3);
        check("t1_err", int'(u.err), 0);
        check("t1_pending", sb.size(), 0);

        // 2: sweep of all glyphs
        for (int g = 0; g < 8; g++) drive(glyph[g], 6);
        check("t2_y", int'(u.y_out), 7);
        check("t2_cnt", int'(u.err_cnt), 0);
        check("t2_pending", sb.size(), 0);

        // 3: short glitch back to the already reported pattern
        drive(7'b0010010, 6);
        drive(7'b1111111, 2);
        drive(7'b0010010, 10);
        check("t3_y", int'(u.y_out), 2);
        check("t3_vld", int'(u.out_vld), 0);

        // 4: illegal patterns and counter saturation
        drive(7'b1111111, 5);
        drive(7'b0000000, 5);
        check("t4_cnt2", int'(u.err_cnt), 2);
        check("t4_y", int'(u.y_out), 0);
        for (int i = 0; i < 260; i++) drive((i % 2 == 0) ? 7'b1111111 : 7'b0000000, S);
        check("t4_sat", int'(u.err_cnt), 255);
        drive(7'h55, 5);
        check("t4_sat_hold", int'(u.err_cnt), 255);
        check("t4_err", int'(u.err), 1);

        // 5: reset mid-count discards the pending run
        drive(7'b0100000, 2);
        rst = 1'b0;
        #1;
        check("t5_rst_y", int'(u.y_out), 0);
        check("t5_rst_err", int'(u.err), 0);
        check("t5_rst_vld", int'(u.out_vld), 0);
        check("t5_rst_cnt", int'(u.err_cnt), 0);
        drive(7'b0100000, 1);
        rst = 1'b1;
        drive(7'b0100000, 6);
        check("t5_y", int'(u.y_out), 6);
        check("t5_pending", sb.size(), 0);

        // 6: STABLE_CYCLES=1 reports on every changing edge
        u1.seg_in = glyph[1];
        drive(u.seg_in, 1);
        check("t6_vld_a", int'(u1.out_vld), 1);
        check("t6_y_a", int'(u1.y_out), 1);
        u1.seg_in = glyph[5];
        drive(u.seg_in, 1);
        check("t6_vld_b", int'(u1.out_vld), 1);
        check("t6_y_b", int'(u1.y_out), 5);
        u1.seg_in = glyph[7];
        drive(u.seg_in, 1);
        check("t6_vld_c", int'(u1.out_vld), 1);
        check("t6_y_c", int'(u1.y_out), 7);
        drive(u.seg_in, 1);
        check("t6_hold_vld", int'(u1.out_vld), 0);
        check("t6_hold_y", int'(u1.y_out), 7);

        drive(u.seg_in, 2);
        check("final_pending", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
